// File: rtl/seq_tx.sv
// Serial pattern transmitter: accepts a word plus bit count over valid/ready and
// shifts the selected bits out MSB-first on D, idling high between words.
module seq_tx #(
   parameter int WIDTH = 8,
   parameter int LW    = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data,
   input  logic [LW-1:0]    len,
   input  logic             valid,
   output logic             ready,
   output logic             D,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_GAP   = 2'b10
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_shreg;
   logic [LW-1:0]    r_cnt;
   logic             r_D;
   logic             r_busy;
   logic             r_done;

   logic [LW-1:0]    w_n;
   logic [LW-1:0]    w_shamt;
   logic [WIDTH-1:0] w_aligned;
   logic             w_accept;

   // The selected bits are left-aligned so the shifter always emits from the MSB.
   assign w_n       = (len > LW'(WIDTH)) ? LW'(WIDTH) : len;
   assign w_shamt   = LW'(WIDTH) - w_n;
   assign w_aligned = data << w_shamt;
   assign ready     = (r_state == S_IDLE);
   assign w_accept  = valid & ready;

   assign D    = r_D;
   assign busy = r_busy;
   assign done = r_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
         r_D     <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_D    <= 1'b1;
               r_done <= 1'b0;
               r_busy <= 1'b0;
               if (w_accept) begin
                  r_cnt  <= w_n;
                  r_busy <= 1'b1;
                  if (w_n != '0) begin
                     // First bit goes straight onto the line at the accept edge.
                     r_state <= S_SHIFT;
                     r_D     <= w_aligned[WIDTH-1];
                     r_shreg <= w_aligned << 1;
                  end else begin
                     r_state <= S_GAP;
                     r_done  <= 1'b1;
                     r_shreg <= '0;
                  end
               end
            end
            S_SHIFT: begin
               r_cnt <= r_cnt - LW'(1);
               if (r_cnt == LW'(1)) begin
                  r_state <= S_GAP;
                  r_D     <= 1'b1;
                  r_done  <= 1'b1;
               end else begin
                  r_D     <= r_shreg[WIDTH-1];
                  r_shreg <= r_shreg << 1;
               end
            end
            S_GAP: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_D     <= 1'b1;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_D     <= 1'b1;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_tx.sv
// Directed bench for seq_tx: per-cycle queue model comparison plus literal checks.
module tb_seq_tx;

   localparam int WIDTH = 8;
   localparam int LW    = $clog2(WIDTH+1);

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [WIDTH-1:0] data = '0;
   logic [LW-1:0]    len = '0;
   logic             valid = 1'b0;
   logic             ready, D, busy, done;

   int total = 0;
   int bad   = 0;

   seq_tx #(.WIDTH(WIDTH), .LW(LW)) dut (
      .clk(clk), .reset(reset), .data(data), .len(len), .valid(valid),
      .ready(ready), .D(D), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: each accepted word becomes a list of per-cycle {D,done,busy} triples.
   logic [2:0] exp_q[$];
   logic [2:0] cur = 3'b100;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         exp_q.delete();
         cur = 3'b100;
      end else begin
         if (valid && !cur[0]) begin
            int n;
            n = (int'(len) > WIDTH) ? WIDTH : int'(len);
            for (int k = n - 1; k >= 0; k--) exp_q.push_back({data[k], 1'b0, 1'b1});
            exp_q.push_back(3'b111);
         end
         if (exp_q.size() > 0) cur = exp_q.pop_front();
         else cur = 3'b100;
      end
   end

   always @(negedge clk) begin
      chk("cmp_D",     D,     cur[2]);
      chk("cmp_done",  done,  cur[1]);
      chk("cmp_busy",  busy,  cur[0]);
      chk("cmp_ready", ready, !cur[0]);
   end

   task automatic wait_idle;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ready) break;
      end
      chk("idle_reached", ready, 1);
   endtask

   // Presents one word for a single cycle; returns just after the accept edge.
   task automatic send(input logic [WIDTH-1:0] d, input logic [LW-1:0] l);
      wait_idle();
      valid = 1'b1; data = d; len = l;
      @(posedge clk);
      #1 valid = 1'b0; data = WIDTH'($urandom); len = LW'($urandom);
   endtask

   task automatic expect_stream(input string nm, input logic [WIDTH-1:0] d, input int n);
      for (int k = n - 1; k >= 0; k--) begin
         @(negedge clk);
         chk(nm, D, d[k]);
      end
   endtask

   initial begin
      logic [7:0] pat;
      logic [2:0] hist;
      int         dcount;

      // Reset held with valid asserted: line idle, nothing accepted.
      valid = 1'b1; data = 8'hA5; len = 4'd8;
      repeat (3) begin
         @(negedge clk);
         chk("rst_D", D, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
      end
      @(posedge clk); #1 reset = 1'b1; data = 8'b0000_0010; len = 4'd2;
      @(posedge clk); #1 valid = 1'b0;
      chk("first_accept_busy", busy, 1);
      chk("first_accept_D", D, 1);

      // Full 8-bit word.
      pat = 8'b1011_0011;
      send(pat, 4'd8);
      expect_stream("full_D", 8'b1011_0011, 8);
      @(negedge clk);
      chk("full_gap_D", D, 1); chk("full_gap_done", done, 1); chk("full_gap_busy", busy, 1);
      @(negedge clk);
      chk("full_ready", ready, 1);

      // 0-1-1 falling-edge recognizer fed by D.
      hist = 3'b111;
      send(8'h03, 4'd3);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         hist = {hist[1:0], D};
         chk("rec_Q", (hist == 3'b011), (c == 3));
      end
      chk("rec_restart", hist[0], 1);

      // len = 0: straight to the gap.
      send(8'hFF, 4'd0);
      @(negedge clk);
      chk("len0_done", done, 1); chk("len0_D", D, 1);
      @(negedge clk);
      chk("len0_ready", ready, 1);

      // len = 15 clamps to 8.
      send(8'b1011_0011, 4'd15);
      expect_stream("clamp_D", 8'b1011_0011, 8);
      @(negedge clk);
      chk("clamp_done", done, 1);

      // len = 1 with a 0 in bit 0.
      send(8'hFE, 4'd1);
      @(negedge clk);
      chk("len1_D", D, 0); chk("len1_done_c1", done, 0);
      @(negedge clk);
      chk("len1_done_c2", done, 1);

      // Continuous valid, len=3: done every 5 cycles at cycles 4,9,14,19,24.
      wait_idle();
      valid = 1'b1; len = 4'd3; data = 8'h5A;
      dcount = 0;
      for (int c = 1; c <= 25; c++) begin
         @(posedge clk); #1 data = WIDTH'($urandom);
         @(negedge clk);
         if (done) dcount++;
      end
      chk("cont_done_count", dcount, 5);
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1 data = WIDTH'($urandom); len = LW'($urandom_range(0, 15));
      end
      valid = 1'b0;

      // Asynchronous reset in cycle 4 of an all-zero word.
      send(8'h00, 4'd8);
      repeat (3) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      chk("midrst_D", D, 1); chk("midrst_busy", busy, 0); chk("midrst_done", done, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      send(8'b0110_1001, 4'd8);
      expect_stream("after_rst_D", 8'b0110_1001, 8);
      @(negedge clk);
      chk("after_rst_done", done, 1);
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule

// File: doc/seq_tx.md
# seq_tx

Serial pattern transmitter: accepts a parallel word and a bit count over a valid/ready handshake and shifts the selected bits out MSB-first on a single serial line, idling high between words. It is the sending end for the serial sequence recognizers in the FSM examples. It drives their `D` input from rising-edge registers, so the line is stable when a falling-edge recognizer samples it.

## Interface

- `WIDTH`, default 8, maximum word length in bits (≥2).
- `LW`, default `$clog2(WIDTH+1)`, width of the `len` port.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `data`  in  WIDTH  word to send; bits `[len-1:0]` are used.
- `len`  in  LW  number of bits to send: 0..WIDTH, with values >WIDTH clamped to WIDTH.
- `valid`  in  1  `data`/`len` are presented.
- `ready`  out  1  block can accept a word this cycle.
- `D`  out  1  serial data line; idle level 1.
- `busy`  out  1  high while in SHIFT or GAP.
- `done`  out  1  one-cycle pulse marking end of a word.

## Operation

- **States:** IDLE, SHIFT, GAP.
- **IDLE**
  - `ready=1`, `D=1`, `busy=0`.
  - On `valid & ready` at a rising edge:
    - Capture `data` into the shift register.
    - Capture the effective length `n = min(len, WIDTH)` into the bit counter.
    - If `n>0`, go to SHIFT. If `n=0`, go to GAP.
- **SHIFT**
  - `D` = current bit, beginning with `data[n-1]` and ending with `data[0]`.
  - The counter decrements each cycle. After the cycle that drives `data[0]`, go to GAP.
- **GAP**
  - Exactly one cycle with `D=1` and `done=1`, then return to IDLE.
  - The gap guarantees at least one idle-high bit between words. This returns a downstream recognizer to its start state.
- **Input handling**
  - `ready=0` in SHIFT and GAP. `valid` is ignored there.
  - `data`/`len` changes after acceptance have no effect.
  - `valid` held continuously gives back-to-back words with one GAP cycle plus one IDLE cycle between them.
- **Output registers:** `D`, `done`, `busy` are registered, with no combinational path from inputs. `ready` is decoded from state only.
- **Reset**
  - Asserting `reset` (low) at any time, including mid-word, forces IDLE immediately.
  - Reset values: `D=1`, `done=0`, `busy=0`, counter 0.
  - The word in flight is discarded. No `done` is issued for it.
  - No transfer is accepted while `reset` is low.
- **Illegal states:** an unreachable state encoding returns to IDLE on the next edge with `D=1`.

## Timing

- **Accept edge:** cycle 0 is the edge where `valid & ready`.
- **Bit cycles:** first bit on `D` is valid after edge 0 through edge 1. Bit k (k=0..n-1) is on `D` during cycle k+1.
- **`done`:** high during cycle n+1 (the GAP cycle), with `D=1`.
- **Next accept:** `ready` returns high in cycle n+2, so the earliest next accept is edge n+2.
- **Word period:** n+2 cycles.
- **n=0:** GAP in cycle 1, `done` in cycle 1, `ready` in cycle 2.
- **Sampling margin:** `D` changes only just after rising edges. A falling-edge sampler sees it stable for half a period on each side.

## Test plan

- **Reset values:** hold `reset` low for 3 cycles with `valid=1`.
  - Required: `D=1`, `busy=0`, `done=0` throughout; no transfer.
  - After release: `ready=1` and first accept on the next edge.
- **Full word, WIDTH=8:** `data=8'b1011_0011`, `len=8`, single-cycle `valid`.
  - Required: `D` = 1,0,1,1,0,0,1,1 over cycles 1–8.
  - Cycle 9: `D=1`, `done=1`, `busy=1`.
  - Cycle 10: `ready=1`.
- **Recognizer cross-check:** `data=8'h03`, `len=3` into the falling-edge 0-1-1 recognizer.
  - Required: `D` = 0,1,1.
  - Recognizer `Q=1` during the third bit cycle only.
  - Recognizer back in start state after GAP.
- **Length boundaries:**
  - `len=0`: no data bits, `done` in cycle 1.
  - `len=15` (clamped to 8): identical `D` stream to `len=8`.
  - `len=1`, `data[0]=0`: single 0 bit, `done` in cycle 2.
- **Continuous `valid`:** hold `valid=1` with `data` changing every cycle.
  - Required: each word matches `data` as sampled at its accept edge only.
  - Accept edges spaced n+2 cycles apart.
- **Reset mid-word:** assert `reset` asynchronously in cycle 4 of an 8-bit word.
  - Required: `D=1` and `busy=0` immediately, without waiting for an edge.
  - No `done` pulse for the aborted word.
  - After release, a new word transmits correctly from its first bit.
